// File: rtl/mem_test_seq_pkg.sv
// Shared definitions for the SRAM march-test sequencer.
//   state_t   : one state per test phase
//   BYTE_*    : byte-lane test data and the words expected back
//   pat()     : march data pattern, derived from the word address and a seed
package mem_test_seq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_W0   = 4'd1,
      ST_R0   = 4'd2,
      ST_W1   = 4'd3,
      ST_R1   = 4'd4,
      ST_BWO  = 4'd5,
      ST_BRO  = 4'd6,
      ST_BWE  = 4'd7,
      ST_BRE  = 4'd8,
      ST_DONE = 4'd9
   } state_t;

   localparam logic [7:0]  BYTE_ODD  = 8'h5A;
   localparam logic [7:0]  BYTE_EVEN = 8'hC3;
   // Byte reads come back sign-extended from the selected lane.
   localparam logic [15:0] EXP_ODD   = 16'h005A;
   localparam logic [15:0] EXP_EVEN  = 16'hFFC3;

   function automatic logic [15:0] pat(input logic [19:0] adr, input logic [15:0] seed);
      return adr[16:1] ^ seed;
   endfunction

endpackage

// File: rtl/mem_test_seq_if.sv
// Request/response bus between the test sequencer and mem_ctrl.
//   adr_o  : byte address          dat_o  : write data
//   we_o   : 1 = write             stb_o  : request strobe
//   byte_o : byte access, lane = adr_o[0]
//   dat_i  : read data (valid with ack_i)   ack_i : transfer complete
interface mem_test_seq_if;
   logic [19:0] adr_o;
   logic [15:0] dat_o;
   logic [15:0] dat_i;
   logic        we_o;
   logic        stb_o;
   logic        byte_o;
   logic        ack_i;

   modport master (output adr_o, dat_o, we_o, stb_o, byte_o, input dat_i, ack_i);
   modport slave  (input adr_o, dat_o, we_o, stb_o, byte_o, output dat_i, ack_i);
endinterface

// File: rtl/mem_test_seq_wdog.sv
// Bus watchdog: counts cycles with stb high and no ack.
//   clk_i, rst_i : clock, synchronous active-high reset
//   stb, ack     : bus handshake being watched
//   expired      : high in the TIMEOUT-th consecutive stalled cycle, so the
//                  owner leaves the transfer on the following edge
module mem_test_wdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic stb,
   input  logic ack,
   output logic expired
);

   localparam int            CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i || !stb || ack) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
   end

   assign expired = stb && !ack && (cnt == LAST);

endmodule

// File: rtl/mem_test_seq.sv
// SRAM march-test bus master sitting in front of mem_ctrl.
// Runs W0/R0 ascending, W1/R1 descending over ADR_LO..ADR_HI, then
// odd/even byte-lane write+read checks, and reports pass/fail with
// first-error capture.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   start_i       : start pulse, honoured only when idle or done
//   bus           : master side of the mem_ctrl request bus
//   busy_o/done_o : running / finished (held until next start)
//   pass_o        : result, valid with done_o
//   err_adr_o/err_exp_o/err_dat_o/err_to_o : first failure capture
module mem_test_seq
   import mem_test_seq_pkg::*;
#(
   parameter logic [19:0] ADR_LO  = 20'h00000,
   parameter logic [19:0] ADR_HI  = 20'h003FE,
   parameter logic [15:0] SEED    = 16'hA55A,
   parameter int          TIMEOUT = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   mem_test_seq_if.master bus,
   output logic          busy_o,
   output logic          done_o,
   output logic          pass_o,
   output logic [19:0]   err_adr_o,
   output logic [15:0]   err_exp_o,
   output logic [15:0]   err_dat_o,
   output logic          err_to_o
);

   state_t      state_q, state_d;
   logic [19:0] adr_q, req_adr;
   logic [15:0] dat_q, req_dat;
   logic        we_q, req_we;
   logic        byte_q, req_byte;
   logic        stb_q, req_stb;
   logic        pass_q, err_to_q;
   logic [19:0] err_adr_q;
   logic [15:0] err_exp_q, err_dat_q;
   logic [15:0] exp_c;
   logic        idle_like, xfer, mis, expired, load, at_hi, at_lo;

   assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
   // ack while stb is low is ignored
   assign xfer      = stb_q && bus.ack_i;
   assign at_hi     = (adr_q == ADR_HI);
   // Descending phases stop on equality, so ADR_LO = 0 never underflows.
   assign at_lo     = (adr_q == ADR_LO);

   // Expected word for the transfer in flight; for writes this is the
   // written data, which is what a write timeout reports.
   always_comb begin
      exp_c = dat_q;
      case (state_q)
         ST_R0:   exp_c = pat(adr_q, SEED);
         ST_R1:   exp_c = ~pat(adr_q, SEED);
         ST_BRO:  exp_c = EXP_ODD;
         ST_BRE:  exp_c = EXP_EVEN;
         default: exp_c = dat_q;
      endcase
   end

   assign mis = xfer && !we_q && (bus.dat_i != exp_c);

   mem_test_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .stb     (stb_q),
      .ack     (bus.ack_i),
      .expired (expired)
   );

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start_i) state_d = ST_W0;
         default: begin
            if (expired) state_d = ST_DONE;
            else if (xfer) begin
               case (state_q)
                  ST_W0:   if (at_hi) state_d = ST_R0;
                  ST_R0:   if (mis) state_d = ST_DONE; else if (at_hi) state_d = ST_W1;
                  ST_W1:   if (at_lo) state_d = ST_R1;
                  ST_R1:   if (mis) state_d = ST_DONE; else if (at_lo) state_d = ST_BWO;
                  ST_BWO:  state_d = ST_BRO;
                  ST_BRO:  state_d = mis ? ST_DONE : ST_BWE;
                  ST_BWE:  state_d = ST_BRE;
                  default: state_d = ST_DONE;   // BRE: done either way, pass_q decides
               endcase
            end
         end
      endcase
   end

   // Outputs and the next request, chosen from the state being entered.
   // Staying in a march phase steps the address; entering one restarts it.
   always_comb begin
      busy_o   = !idle_like;
      done_o   = (state_q == ST_DONE);
      req_adr  = '0;
      req_dat  = '0;
      req_we   = 1'b0;
      req_byte = 1'b0;
      req_stb  = 1'b1;
      case (state_d)
         ST_W0: begin
            req_adr = (state_q == ST_W0) ? adr_q + 20'd2 : ADR_LO;
            req_dat = pat(req_adr, SEED);
            req_we  = 1'b1;
         end
         ST_R0: req_adr = (state_q == ST_R0) ? adr_q + 20'd2 : ADR_LO;
         ST_W1: begin
            req_adr = (state_q == ST_W1) ? adr_q - 20'd2 : ADR_HI;
            req_dat = ~pat(req_adr, SEED);
            req_we  = 1'b1;
         end
         ST_R1: req_adr = (state_q == ST_R1) ? adr_q - 20'd2 : ADR_HI;
         ST_BWO: begin
            req_adr  = ADR_LO | 20'd1;
            req_dat  = {BYTE_ODD, BYTE_ODD};
            req_we   = 1'b1;
            req_byte = 1'b1;
         end
         ST_BRO: begin
            req_adr  = ADR_LO | 20'd1;
            req_byte = 1'b1;
         end
         ST_BWE: begin
            req_adr  = ADR_LO;
            req_dat  = {BYTE_EVEN, BYTE_EVEN};
            req_we   = 1'b1;
            req_byte = 1'b1;
         end
         ST_BRE: begin
            req_adr  = ADR_LO;
            req_byte = 1'b1;
         end
         default: req_stb = 1'b0;
      endcase
   end

   // Request registers only move on start, ack or timeout, so they hold
   // stable through wait states and stb stays high across phases.
   assign load = idle_like ? start_i : (xfer || expired);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         adr_q     <= '0;
         dat_q     <= '0;
         we_q      <= 1'b0;
         byte_q    <= 1'b0;
         stb_q     <= 1'b0;
         pass_q    <= 1'b0;
         err_to_q  <= 1'b0;
         err_adr_q <= '0;
         err_exp_q <= '0;
         err_dat_q <= '0;
      end else begin
         if (load) begin
            adr_q  <= req_adr;
            dat_q  <= req_dat;
            we_q   <= req_we;
            byte_q <= req_byte;
            stb_q  <= req_stb;
         end
         if (idle_like) begin
            if (start_i) begin
               pass_q    <= 1'b0;
               err_to_q  <= 1'b0;
               err_adr_q <= '0;
               err_exp_q <= '0;
               err_dat_q <= '0;
            end
         end else if (expired) begin
            err_to_q  <= 1'b1;
            err_adr_q <= adr_q;
            err_exp_q <= exp_c;
            err_dat_q <= '0;
         end else if (mis) begin
            err_adr_q <= adr_q;
            err_exp_q <= exp_c;
            err_dat_q <= bus.dat_i;
         end else if (xfer && state_q == ST_BRE) begin
            pass_q <= 1'b1;
         end
      end
   end

   assign bus.adr_o  = adr_q;
   assign bus.dat_o  = dat_q;
   assign bus.we_o   = we_q;
   assign bus.byte_o = byte_q;
   assign bus.stb_o  = stb_q;
   assign pass_o     = pass_q;
   assign err_to_o   = err_to_q;
   assign err_adr_o  = err_adr_q;
   assign err_exp_o  = err_exp_q;
   assign err_dat_o  = err_dat_q;

endmodule

// File: tb/tb_mem_test_seq.sv
// Directed bench for mem_test_seq over a 4-word RAM (ADR 0..6) with a
// behavioural memory responder: configurable wait states, a hang at
// address 2, zero-extended byte reads and single-bit read faults.
module tb_mem_test_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic        busy_o, done_o, pass_o, err_to_o;
   logic [19:0] err_adr_o;
   logic [15:0] err_exp_o, err_dat_o;

   int n_cmp = 0;
   int n_err = 0;

   // responder configuration, written only by the initial block
   int   wait_cycles = 0;
   logic hang_en = 1'b0;
   logic zext = 1'b0;
   int   fault = 0;

   logic [15:0] mem [0:7];
   int          wcnt = 0;
   int          rd4 = 0;
   logic [15:0] word, rd;
   logic [7:0]  bsel;

   // captured by run()
   logic [19:0] wadr [0:3];
   logic [15:0] wdat [0:3];
   int          nw;
   logic        c1_stb, c1_done, c1_to;
   logic [15:0] c1_exp;

   always #5 clk = ~clk;

   mem_test_seq_if bus ();

   mem_test_seq #(.ADR_LO(20'h0), .ADR_HI(20'h6), .SEED(16'hA55A), .TIMEOUT(16)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start_i),
      .bus       (bus),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .pass_o    (pass_o),
      .err_adr_o (err_adr_o),
      .err_exp_o (err_exp_o),
      .err_dat_o (err_dat_o),
      .err_to_o  (err_to_o)
   );

   // ---------------- memory responder ----------------
   assign bus.ack_i = bus.stb_o && (wcnt == wait_cycles) &&
                      !(hang_en && bus.we_o && !bus.byte_o && bus.adr_o == 20'h2);

   always @(posedge clk) begin
      if (rst || !bus.stb_o || bus.ack_i) wcnt <= 0;
      else                                wcnt <= wcnt + 1;
      if (start_i && !busy_o) rd4 <= 0;
      else if (bus.stb_o && bus.ack_i && !bus.we_o && bus.adr_o == 20'h4) rd4 <= rd4 + 1;
      if (bus.stb_o && bus.ack_i && bus.we_o) begin
         if (!bus.byte_o)       mem[bus.adr_o[3:1]]       <= bus.dat_o;
         else if (bus.adr_o[0]) mem[bus.adr_o[3:1]][15:8] <= bus.dat_o[15:8];
         else                   mem[bus.adr_o[3:1]][7:0]  <= bus.dat_o[7:0];
      end
   end

   always_comb begin
      word = mem[bus.adr_o[3:1]];
      bsel = bus.adr_o[0] ? word[15:8] : word[7:0];
      rd   = word;
      if (bus.byte_o) rd = zext ? {8'h00, bsel} : {{8{bsel[7]}}, bsel};
      if (fault == 1 && bus.adr_o == 20'h4 && rd4 == 0) rd[3] = 1'b0;
      if (fault == 2 && bus.adr_o == 20'h4 && rd4 == 1) rd[3] = 1'b1;
      bus.dat_i = rd;
   end

   // Pulse start, then count cycles until done_o (cycle 1 = cycle after
   // the start pulse). Optionally pulses start again at cycle 'poke'.
   task automatic run(input int poke, input int limit, output int cyc,
                      output int xfers, output int stab_err);
      logic        prev_stall;
      logic [19:0] padr;
      logic [15:0] pdat;
      logic        pwe;
      nw = 0; xfers = 0; stab_err = 0; prev_stall = 1'b0;
      padr = '0; pdat = '0; pwe = 1'b0;
      @(negedge clk); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0; cyc = 1;
      c1_stb = bus.stb_o; c1_done = done_o; c1_to = err_to_o; c1_exp = err_exp_o;
      while (!done_o && cyc < limit) begin
         if (prev_stall && (bus.adr_o !== padr || bus.dat_o !== pdat || bus.we_o !== pwe))
            stab_err++;
         prev_stall = bus.stb_o && !bus.ack_i;
         padr = bus.adr_o; pdat = bus.dat_o; pwe = bus.we_o;
         if (bus.stb_o && bus.ack_i) begin
            xfers++;
            if (bus.we_o && !bus.byte_o && nw < 4) begin
               wadr[nw] = bus.adr_o; wdat[nw] = bus.dat_o; nw++;
            end
         end
         start_i = (cyc == poke);
         @(negedge clk); cyc++;
      end
      start_i = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      n_cmp++; if ({busy_o, done_o, pass_o, err_to_o, bus.stb_o} !== 5'b0) begin
         n_err++; $display("FAIL reset_flags: got %b want 00000", {busy_o, done_o, pass_o, err_to_o, bus.stb_o});
      end
      n_cmp++; if ({err_adr_o, err_exp_o, err_dat_o, bus.adr_o, bus.dat_o} !== '0) begin
         n_err++; $display("FAIL reset_buses: got %h/%h/%h/%h/%h want 0", err_adr_o, err_exp_o, err_dat_o, bus.adr_o, bus.dat_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      int cyc, xf, se;
      logic [15:0] exp_w [0:3];
      exp_w[0] = 16'hA55A; exp_w[1] = 16'hA55B; exp_w[2] = 16'hA558; exp_w[3] = 16'hA559;
      run(0, 200, cyc, xf, se);
      n_cmp++; if (c1_stb !== 1'b1) begin n_err++; $display("FAIL basic_first_stb: got %b want 1", c1_stb); end
      n_cmp++; if (cyc !== 21) begin n_err++; $display("FAIL basic_cycles: got %0d want 21", cyc); end
      n_cmp++; if (xf !== 20) begin n_err++; $display("FAIL basic_xfers: got %0d want 20", xf); end
      n_cmp++; if ({done_o, pass_o, busy_o, bus.stb_o} !== 4'b1100) begin
         n_err++; $display("FAIL basic_done_pass: got %b want 1100", {done_o, pass_o, busy_o, bus.stb_o});
      end
      n_cmp++; if ({err_to_o, err_adr_o, err_exp_o, err_dat_o} !== '0) begin
         n_err++; $display("FAIL basic_err_zero: got %b/%h/%h/%h want 0", err_to_o, err_adr_o, err_exp_o, err_dat_o);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (wadr[i] !== 20'(2 * i) || wdat[i] !== exp_w[i]) begin
            n_err++; $display("FAIL basic_w0_%0d: got %h@%h want %h@%h", i, wdat[i], wadr[i], exp_w[i], 20'(2 * i));
         end
      end
      // done is held
      repeat (3) @(negedge clk);
      n_cmp++; if ({done_o, pass_o} !== 2'b11) begin n_err++; $display("FAIL basic_hold: got %b want 11", {done_o, pass_o}); end
   endtask

   task automatic test_stuck_r0;
      int cyc, xf, se;
      fault = 1;   // bit 3 stuck at 0 on first read of address 4 (R0)
      run(0, 200, cyc, xf, se);
      fault = 0;
      n_cmp++; if ({done_o, pass_o, err_to_o} !== 3'b100) begin
         n_err++; $display("FAIL r0_flags: got %b want 100", {done_o, pass_o, err_to_o});
      end
      n_cmp++; if (err_adr_o !== 20'h4 || err_exp_o !== 16'hA558 || err_dat_o !== 16'hA550) begin
         n_err++; $display("FAIL r0_capture: got %h/%h/%h want 00004/a558/a550", err_adr_o, err_exp_o, err_dat_o);
      end
      n_cmp++; if (cyc !== 8 || xf !== 7) begin
         n_err++; $display("FAIL r0_stop: got cyc %0d xfers %0d want 8/7", cyc, xf);
      end
   endtask

   task automatic test_stuck_r1;
      int cyc, xf, se;
      fault = 2;   // bit 3 stuck at 1 on second read of address 4 (R1)
      run(0, 200, cyc, xf, se);
      fault = 0;
      n_cmp++; if (c1_exp !== 16'h0000 || c1_done !== 1'b0) begin
         n_err++; $display("FAIL r1_restart_clear: got exp %h done %b want 0000/0", c1_exp, c1_done);
      end
      n_cmp++; if ({done_o, pass_o, err_to_o} !== 3'b100) begin
         n_err++; $display("FAIL r1_flags: got %b want 100", {done_o, pass_o, err_to_o});
      end
      n_cmp++; if (err_adr_o !== 20'h4 || err_exp_o !== 16'h5AA7 || err_dat_o !== 16'h5AAF) begin
         n_err++; $display("FAIL r1_capture: got %h/%h/%h want 00004/5aa7/5aaf", err_adr_o, err_exp_o, err_dat_o);
      end
   endtask

   task automatic test_zext;
      int cyc, xf, se;
      zext = 1'b1;
      run(0, 200, cyc, xf, se);
      zext = 1'b0;
      n_cmp++; if ({done_o, pass_o, err_to_o} !== 3'b100) begin
         n_err++; $display("FAIL zext_flags: got %b want 100", {done_o, pass_o, err_to_o});
      end
      n_cmp++; if (err_adr_o !== 20'h0 || err_exp_o !== 16'hFFC3 || err_dat_o !== 16'h00C3) begin
         n_err++; $display("FAIL zext_capture: got %h/%h/%h want 00000/ffc3/00c3", err_adr_o, err_exp_o, err_dat_o);
      end
      n_cmp++; if (cyc !== 21) begin n_err++; $display("FAIL zext_cycles: got %0d want 21", cyc); end
   endtask

   task automatic test_timeout;
      int cyc, xf, se;
      hang_en = 1'b1;
      run(0, 200, cyc, xf, se);
      hang_en = 1'b0;
      // adr 0 acked in cycle 1, adr 2 stalls cycles 2..17, done in 18
      n_cmp++; if (cyc !== 18) begin n_err++; $display("FAIL to_cycles: got %0d want 18", cyc); end
      n_cmp++; if ({done_o, pass_o, err_to_o, bus.stb_o} !== 4'b1010) begin
         n_err++; $display("FAIL to_flags: got %b want 1010", {done_o, pass_o, err_to_o, bus.stb_o});
      end
      n_cmp++; if (err_adr_o !== 20'h2 || err_exp_o !== 16'hA55B || err_dat_o !== 16'h0000) begin
         n_err++; $display("FAIL to_capture: got %h/%h/%h want 00002/a55b/0000", err_adr_o, err_exp_o, err_dat_o);
      end
   endtask

   task automatic test_wait;
      int cyc, xf, se;
      wait_cycles = 3;
      run(0, 400, cyc, xf, se);
      wait_cycles = 0;
      n_cmp++; if (c1_to !== 1'b0) begin n_err++; $display("FAIL wait_restart_clear: got %b want 0", c1_to); end
      n_cmp++; if (cyc !== 81) begin n_err++; $display("FAIL wait_cycles: got %0d want 81", cyc); end
      n_cmp++; if (xf !== 20) begin n_err++; $display("FAIL wait_xfers: got %0d want 20", xf); end
      n_cmp++; if (se !== 0) begin n_err++; $display("FAIL wait_stable: got %0d changes want 0", se); end
      n_cmp++; if ({done_o, pass_o} !== 2'b11) begin n_err++; $display("FAIL wait_pass: got %b want 11", {done_o, pass_o}); end
   endtask

   task automatic test_restart;
      int cyc, xf, se;
      run(0, 11, cyc, xf, se);   // stopped in W1 (transfers 9..12)
      n_cmp++; if (busy_o !== 1'b1 || bus.we_o !== 1'b1 || bus.adr_o !== 20'h2) begin
         n_err++; $display("FAIL rst_mid_w1: got busy %b we %b adr %h want 1/1/00002", busy_o, bus.we_o, bus.adr_o);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if ({bus.stb_o, busy_o, done_o, pass_o, err_to_o} !== 5'b0 || err_adr_o !== 20'h0) begin
         n_err++; $display("FAIL rst_abort: got %b adr %h want 00000 adr 00000", {bus.stb_o, busy_o, done_o, pass_o, err_to_o}, err_adr_o);
      end
      rst = 1'b0;
      @(negedge clk);
      run(5, 200, cyc, xf, se);   // extra start at cycle 5 must be ignored
      n_cmp++; if (cyc !== 21 || xf !== 20) begin
         n_err++; $display("FAIL restart_timing: got cyc %0d xfers %0d want 21/20", cyc, xf);
      end
      n_cmp++; if ({done_o, pass_o, err_to_o} !== 3'b110) begin
         n_err++; $display("FAIL restart_pass: got %b want 110", {done_o, pass_o, err_to_o});
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stuck_r0();
      test_stuck_r1();
      test_zext();
      test_timeout();
      test_wait();
      test_restart();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
